// File: rtl/ram8_arb.sv
// ram8_arb: two-master round-robin arbiter/sequencer driving one RAM8 access per transaction.
// Optional macro RAM8_ARB_FIXED_PRI_EN selects fixed priority (master 0 wins ties).
`default_nettype none

module ram8_arb #(
    parameter int AW = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          ram_e,
    output logic          ram_w,
    output logic          ram_r,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    r_state;
    logic          r_win;
    logic          w_any;
    logic          w_gnt1;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    assign w_any = req0 | req1;

`ifdef RAM8_ARB_FIXED_PRI_EN
    assign w_gnt1 = req1 & ~req0;
`else
    // r_last = id of the master served most recently; the other one wins a tie
    logic r_last;

    assign w_gnt1 = req1 & (~req0 | ~r_last);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_last <= 1'b1;
        end else if (r_state == S_IDLE && w_any) begin
            r_last <= w_gnt1;
        end
    end
`endif

    assign w_we    = w_gnt1 ? we1    : we0;
    assign w_addr  = w_gnt1 ? addr1  : addr0;
    assign w_wdata = w_gnt1 ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state  <= S_IDLE;
            r_win    <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
            ram_e    <= 1'b0;
            ram_w    <= 1'b0;
            ram_r    <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state  <= S_ACC;
                        r_win    <= w_gnt1;
                        ram_e    <= 1'b1;
                        ram_w    <= w_we;
                        ram_r    <= ~w_we;
                        ram_addr <= w_addr;
                        ram_din  <= w_wdata;
                    end
                end
                S_ACC: begin
                    // ram_w still reflects the latched direction during this cycle
                    if (!ram_w) begin
                        rdata <= ram_dout;
                    end
                    ram_e   <= 1'b0;
                    ram_w   <= 1'b0;
                    ram_r   <= 1'b0;
                    ack0    <= ~r_win;
                    ack1    <= r_win;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    ram_e   <= 1'b0;
                    ram_w   <= 1'b0;
                    ram_r   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram8_arb.sv
// tb_ram8_arb: directed table-driven bench for ram8_arb with a behavioural RAM8 model.
`default_nettype none

module tb_ram8_arb;

    logic        clk;
    logic        rst_;
    logic        req0, req1, we0, we1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata;
    logic        ram_e, ram_w, ram_r;
    logic [2:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    int tests_run = 0;
    int tests_failed = 0;

    ram8_arb #(.AW(3), .DW(16)) dut (
        .clk(clk), .rst_(rst_),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .ram_e(ram_e), .ram_w(ram_w), .ram_r(ram_r),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // RAM8 model: synchronous write, combinational read, no reset
    logic [15:0] mem [8];
    always @(posedge clk) begin
        if (ram_e && ram_w) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ = 1'b0;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic txn(input int m, input logic we, input logic [2:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd);
        bit seen_acc;
        bit done;
        seen_acc = 0;
        done = 0;
        repeat (2) @(posedge clk);
        #1;
        if (m == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (ram_e && !seen_acc) begin
                seen_acc = 1;
                chk("acc_cycle", c, 1);
                chk("ram_w", {31'd0, ram_w}, {31'd0, we});
                chk("ram_r", {31'd0, ram_r}, {31'd0, !we});
                chk("ram_addr", {29'd0, ram_addr}, {29'd0, a});
                chk("ram_din", {16'd0, ram_din}, {16'd0, d});
            end
            if (ack0 || ack1) begin
                done = 1;
                chk("ack_cycle", c, 2);
                chk("ack_id", {30'd0, ack1, ack0}, (m == 0) ? 32'd1 : 32'd2);
                chk("rdata", {16'd0, rdata}, {16'd0, exp_rd});
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        if (!seen_acc) chk("acc_seen", 0, 1);
        if (!done) chk("ack_timeout", 0, 1);
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] rd;
    } vec_t;

    vec_t        tbl [9];
    logic [15:0] last_rd;
    logic [15:0] bb_data [3];
    bit          exp_a0, exp_a1;

    initial begin
        tbl[0] = '{0, 1'b1, 3'd5, 16'hA5A5, 16'h0000};
        tbl[1] = '{0, 1'b0, 3'd5, 16'h0000, 16'hA5A5};
        tbl[2] = '{1, 1'b1, 3'd3, 16'hBEEF, 16'hA5A5};
        tbl[3] = '{1, 1'b0, 3'd3, 16'h0000, 16'hBEEF};
        tbl[4] = '{0, 1'b1, 3'd2, 16'h0000, 16'hBEEF};
        tbl[5] = '{1, 1'b0, 3'd5, 16'h0000, 16'hA5A5};
        tbl[6] = '{0, 1'b1, 3'd7, 16'hFFFF, 16'hA5A5};
        tbl[7] = '{0, 1'b0, 3'd7, 16'h0000, 16'hFFFF};
        tbl[8] = '{1, 1'b1, 3'd3, 16'h1234, 16'hFFFF};
        bb_data[0] = 16'hC000;
        bb_data[1] = 16'hC001;
        bb_data[2] = 16'hC002;

        // Reset held with both masters requesting
        rst_ = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 3'd6; addr1 = 3'd4; wdata0 = 16'h5555; wdata1 = 16'h6666;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ctrl", {27'd0, ack0, ack1, ram_e, ram_w, ram_r}, 32'd0);
            chk("rst_addr", {29'd0, ram_addr}, 32'd0);
            chk("rst_din", {16'd0, ram_din}, 32'd0);
            chk("rst_rdata", {16'd0, rdata}, 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;
        rst_ = 1'b1;

        for (int i = 0; i < 9; i++) begin
            txn(tbl[i].m, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rd);
        end

        // Tie right after reset, both held
        do_reset();
        @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd1; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 16'h2222;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
`ifdef RAM8_ARB_FIXED_PRI_EN
            exp_a0 = (c % 3 == 2);
            exp_a1 = 1'b0;
`else
            exp_a0 = (c == 2) || (c == 8);
            exp_a1 = (c == 5) || (c == 11);
`endif
            chk("tie_ack0", {31'd0, ack0}, {31'd0, exp_a0});
            chk("tie_ack1", {31'd0, ack1}, {31'd0, exp_a1});
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("tie_quiet", {30'd0, ack0, ack1}, 32'd0);
        end
        txn(0, 1'b0, 3'd1, 16'h0000, 16'h1111);
`ifdef RAM8_ARB_FIXED_PRI_EN
        txn(1, 1'b0, 3'd2, 16'h0000, 16'h0000);
        last_rd = 16'h0000;
`else
        txn(1, 1'b0, 3'd2, 16'h0000, 16'h2222);
        last_rd = 16'h2222;
`endif

        // Reset asserted during a write access
        txn(0, 1'b1, 3'd2, 16'h0000, last_rd);
        repeat (2) @(posedge clk);
        #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_acc", {30'd0, ram_e, ram_w}, 32'd3);
        #1;
        rst_ = 1'b0;
        #1;
        chk("abort_ctrl", {27'd0, ack0, ack1, ram_e, ram_w, ram_r}, 32'd0);
        req1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_ack", {30'd0, ack0, ack1}, 32'd0);
        end
        rst_ = 1'b1;
        txn(0, 1'b0, 3'd5, 16'h0000, 16'hA5A5);
        txn(1, 1'b0, 3'd2, 16'h0000, 16'h0000);

        // Single master holding req: three writes then three reads
        repeat (2) @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd0; wdata0 = bb_data[0];
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            chk("b2b_ack0", {31'd0, ack0}, {31'd0, (c % 3 == 2)});
            if (c % 3 == 2) begin
                if (c / 3 >= 3) chk("b2b_rdata", {16'd0, rdata}, {16'd0, bb_data[c / 3 - 3]});
                if (c / 3 + 1 < 6) begin
                    we0    = (c / 3 + 1 < 3);
                    addr0  = 3'((c / 3 + 1) % 3);
                    wdata0 = 16'h0;
                    if (c / 3 + 1 < 3) wdata0 = bb_data[c / 3 + 1];
                end else begin
                    req0 = 1'b0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram8_arb.md
# ram8_arb

Two-requester arbiter and sequencer for the 8 x 16-bit `RAM8` register file. It accepts independent read/write requests from two masters, picks one per transaction, and drives the RAM8 control pins (`e`, `w`, `r`, `addr`, `DIn`) for exactly one access cycle. It captures `DOut` and returns a one-cycle acknowledge with read data. It sits between the datapath masters and the single RAM8 instance.

## Interface

Parameters:
- `AW`, default 3: address width; must match the RAM8 `addr` width.
- `DW`, default 16: data width; must match the RAM8 `DIn`/`DOut` width.

Ports:
- `clk` input 1: single clock, rising edge. One clock; reset is asynchronous and active-low.
- `rst_` input 1: asynchronous, active-low reset.
- `req0`, `req1` input 1: request level from master 0 and master 1.
- `we0`, `we1` input 1: 1 = write, 0 = read. Held stable while `reqN` is high.
- `addr0`, `addr1` input AW: word address.
- `wdata0`, `wdata1` input DW: write data.
- `ack0`, `ack1` output 1: one-cycle pulse marking completion of one transaction.
- `rdata` output DW: read data. Valid in the cycle `ackN` is high, for read transactions only.
- `ram_e`, `ram_w`, `ram_r` output 1: drive RAM8 `e`, `w`, `r`.
- `ram_addr` output AW: drives RAM8 `addr`.
- `ram_din` output DW: drives RAM8 `DIn`.
- `ram_dout` input DW: connected to RAM8 `DOut`.

## Operation

- The FSM has three states: IDLE, ACC, RESP.
- **IDLE**
  - If no request is pending, the FSM stays in IDLE.
  - Otherwise it selects a winner, latches that master's `we`, `addr` and `wdata` into internal registers, and moves to ACC.
  - It also records the winner id.
- **ACC**
  - For one cycle, `ram_e` = 1, `ram_addr` = latched address, and `ram_din` = latched data.
  - On a write: `ram_w` = 1 and `ram_r` = 0.
  - On a read: `ram_r` = 1 and `ram_w` = 0.
  - At the closing edge, a write commits into RAM8 and a read captures `ram_dout` into `rdata`.
  - Next state is RESP.
- **RESP**
  - `ack<winner>` = 1 for this cycle only.
  - All `ram_*` controls are 0.
  - Next state is IDLE.
- Outside ACC, `ram_e`, `ram_w` and `ram_r` are 0. `ram_addr` and `ram_din` hold their last values.
- **Arbitration:** round-robin with a last-served pointer.
  - When both masters request in IDLE, the master not served last wins.
  - After reset the pointer equals 1, so master 0 wins the first tie.
- **Request protocol**
  - `reqN` held high after `ackN` is treated as a new transaction.
  - Dropping `reqN` before `ackN` is a protocol violation. The already-latched transaction still completes and is acknowledged.
  - Changing `weN`, `addrN` or `wdataN` after latch has no effect on the current transaction.
- `rdata` holds its value until the next read capture. It is unchanged by writes.

## Timing

- All outputs are registered.
- **Reset values:**
  - State is IDLE and the pointer is 1.
  - `ack0`, `ack1`, `ram_e`, `ram_w` and `ram_r` are 0.
  - `ram_addr`, `ram_din` and `rdata` are 0.
- **Latency:** a request sampled high at edge k gives ACC during cycle k..k+1 and `ack` during cycle k+1..k+2. Measured from the first cycle `req` is high, `ack` appears 2 cycles later.
- **Throughput:** one transaction per 3 cycles.
- **Continuous requests:**
  - A single master holding `req` is acknowledged every 3 cycles.
  - With both holding `req`, acknowledges alternate between the masters: 3-cycle spacing between consecutive acks and 6-cycle spacing per master.
- **Reset mid-operation:**
  - `rst_` low clears all outputs immediately, without waiting for a clock.
  - A write in ACC that has not yet reached its closing edge is not performed.
  - No `ack` is issued for the aborted transaction.
  - RAM8 contents are not cleared, because RAM8 has no reset.
- A request arriving while the FSM is in ACC or RESP waits and is evaluated in the next IDLE cycle.

## Configuration

- `RAM8_ARB_FIXED_PRI_EN`
  - Defined: fixed priority. Master 0 always wins a tie; master 1 is served only when `req0` is low in IDLE. The pointer logic is removed.
  - Undefined (default): round-robin as described above.

## Test plan

- **Reset:** `rst_` = 0 with both `req` high → all outputs 0; no `ack` while reset is held.
- **Single master write then read:** master 0 writes `addr` 5, `wdata` 16'hA5A5 → `ram_w` high for 1 cycle, `ack0` 2 cycles after `req0`. A following read of `addr` 5 → `rdata` = 16'hA5A5 with `ack0`.
- **Tie after reset (round-robin):**
  - `req0` and `req1` rise together, master 0 writing 16'h1111 to `addr` 1 and master 1 writing 16'h2222 to `addr` 2 → `ack0` at cycle 2, `ack1` at cycle 5.
  - Both held → acknowledges continue alternating every 3 cycles.
- **Fixed priority (`RAM8_ARB_FIXED_PRI_EN` defined):** both `req` held for 12 cycles → `ack0` at cycles 2, 5, 8, 11 and `ack1` never.
- **Reset during write:** `addr` 2 holds 16'h0000 and master 1 writes 16'h1234 → assert `rst_` in the ACC cycle → `ram_w` falls immediately, no `ack1`. A read of `addr` 2 → 16'h0000.
- **Back-to-back single master:** `req0` held for writes to `addr` 0, 1, 2, then reads of the same addresses → acks at cycles 2, 5, 8, then read data matches the written values.
